zeroheti_obi_arb: RTL and testbench

- Two-manager to one-subordinate OBI arbiter.
- Shares the system bus port between the core data port (manager 0) and the debug module's system-bus-access manager (manager 1).
- Tracks outstanding transactions in an in-order ID FIFO so each response returns to its issuer.
- Sits between the debug wrapper's SBA manager, the core LSU and the system crossbar.

---
 rtl/zeroheti_obi_arb.sv | 116 +++++++++++
 tb/tb_zeroheti_obi_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/zeroheti_obi_arb.sv
// zeroheti_obi_arb: two-manager to one-subordinate OBI arbiter with in-order response routing.
// Define ZEROHETI_ARB_DBG_PRIO_EN to give the SBA manager fixed priority over the core.
module zeroheti_obi_arb #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned MaxTrans  = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   m0_req_i,
   output logic                   m0_gnt_o,
   input  logic [AddrWidth-1:0]   m0_addr_i,
   input  logic                   m0_we_i,
   input  logic [DataWidth/8-1:0] m0_be_i,
   input  logic [DataWidth-1:0]   m0_wdata_i,
   output logic                   m0_rvalid_o,
   output logic [DataWidth-1:0]   m0_rdata_o,
   output logic                   m0_err_o,
   input  logic                   m1_req_i,
   output logic                   m1_gnt_o,
   input  logic [AddrWidth-1:0]   m1_addr_i,
   input  logic                   m1_we_i,
   input  logic [DataWidth/8-1:0] m1_be_i,
   input  logic [DataWidth-1:0]   m1_wdata_i,
   output logic                   m1_rvalid_o,
   output logic [DataWidth-1:0]   m1_rdata_o,
   output logic                   m1_err_o,
   output logic                   s_req_o,
   input  logic                   s_gnt_i,
   output logic [AddrWidth-1:0]   s_addr_o,
   output logic                   s_we_o,
   output logic [DataWidth/8-1:0] s_be_o,
   output logic [DataWidth-1:0]   s_wdata_o,
   input  logic                   s_rvalid_i,
   input  logic [DataWidth-1:0]   s_rdata_i,
   input  logic                   s_err_i,
   output logic                   spurious_o
);
   localparam int unsigned CW = $clog2(MaxTrans + 1);
   localparam int unsigned PW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

   logic                rr_ptr, lock, lock_idx, sel, full, push, pop, head;
   logic [CW-1:0]       cnt;
   logic [PW-1:0]       wptr, rptr;
   logic [MaxTrans-1:0] fifo;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(MaxTrans - 1)) ? '0 : p + 1'b1;
   endfunction

   // A stalled request stays locked to its manager until it is granted.
   always_comb begin
      sel = m1_req_i;
      if (lock)
         sel = lock_idx;
      else if (m0_req_i & m1_req_i)
`ifdef ZEROHETI_ARB_DBG_PRIO_EN
         sel = 1'b1;
`else
         sel = rr_ptr;
`endif
   end

   assign full      = (cnt == CW'(MaxTrans));
   assign s_req_o   = (sel ? m1_req_i : m0_req_i) & ~full;
   assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
   assign s_we_o    = sel ? m1_we_i    : m0_we_i;
   assign s_be_o    = sel ? m1_be_i    : m0_be_i;
   assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

   assign push     = s_req_o & s_gnt_i;
   assign m0_gnt_o = push & ~sel & ~rst_i;
   assign m1_gnt_o = push & sel & ~rst_i;

   // Responses follow issue order, so the FIFO head names the owner.
   assign pop         = s_rvalid_i & (cnt != '0);
   assign head        = fifo[rptr];
   assign m0_rvalid_o = pop & ~head;
   assign m1_rvalid_o = pop & head;
   assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
   assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;
   assign m0_err_o    = m0_rvalid_o & s_err_i;
   assign m1_err_o    = m1_rvalid_o & s_err_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr     <= 1'b0;
         lock       <= 1'b0;
         lock_idx   <= 1'b0;
         cnt        <= '0;
         wptr       <= '0;
         rptr       <= '0;
         fifo       <= '0;
         spurious_o <= 1'b0;
      end else begin
         if (push) begin
            fifo[wptr] <= sel;
            wptr       <= inc(wptr);
`ifdef ZEROHETI_ARB_DBG_PRIO_EN
            rr_ptr     <= 1'b0;
`else
            rr_ptr     <= ~sel;
`endif
            lock       <= 1'b0;
         end else if (s_req_o) begin
            lock     <= 1'b1;
            lock_idx <= sel;
         end
         if (pop)
            rptr <= inc(rptr);
         cnt <= cnt + CW'(push) - CW'(pop);
         if (s_rvalid_i && cnt == '0)
            spurious_o <= 1'b1;
      end
   end
endmodule

// File: tb/tb_zeroheti_obi_arb.sv
// tb_zeroheti_obi_arb: directed self-checking bench for zeroheti_obi_arb (default MaxTrans=2).
module tb_zeroheti_obi_arb;
   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o, m0_err_o;
   logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o, m1_err_o;
   logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o, m1_addr_i, m1_wdata_i, m1_rdata_o;
   logic [3:0]  m0_be_i, m1_be_i, s_be_o;
   logic        s_req_o, s_gnt_i, s_we_o, s_rvalid_i, s_err_i, spurious_o;
   logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
   int total = 0, bad = 0;

   always #5 clk_i = ~clk_i;

   zeroheti_obi_arb dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
      .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o),
      .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
      .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
      .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o),
      .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
      .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
      .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i),
      .s_rdata_i(s_rdata_i), .s_err_i(s_err_i), .spurious_o(spurious_o)
   );

   task automatic tick;
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic clear_inputs;
      m0_req_i = 0; m0_addr_i = 32'h0; m0_we_i = 0; m0_be_i = 4'hF; m0_wdata_i = 32'h0;
      m1_req_i = 0; m1_addr_i = 32'h0; m1_we_i = 0; m1_be_i = 4'hF; m1_wdata_i = 32'h0;
      s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = 32'h0; s_err_i = 0;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst_i = 1;
      tick();
      rst_i = 0;
   endtask

   task automatic test_reset;
      @(negedge clk_i);
      rst_i = 1;
      m0_req_i = 1; m1_req_i = 1; s_gnt_i = 1; s_rvalid_i = 1; s_rdata_i = 32'h55;
      #1;
      total++; if (m0_gnt_o !== 1'b0) begin bad++; $display("FAIL reset_m0_gnt got=%b exp=0", m0_gnt_o); end
      total++; if (m1_gnt_o !== 1'b0) begin bad++; $display("FAIL reset_m1_gnt got=%b exp=0", m1_gnt_o); end
      total++; if (m0_rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_m0_rvalid got=%b exp=0", m0_rvalid_o); end
      total++; if (m1_rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_m1_rvalid got=%b exp=0", m1_rvalid_o); end
      tick();
      total++; if (spurious_o !== 1'b0) begin bad++; $display("FAIL reset_spurious got=%b exp=0", spurious_o); end
      clear_inputs();
      rst_i = 0;
   endtask

   task automatic test_single_read;
      do_reset();
      m0_req_i = 1; m0_addr_i = 32'h100; s_gnt_i = 1;
      #1;
      total++; if (m0_gnt_o !== 1'b1) begin bad++; $display("FAIL single_m0_gnt got=%b exp=1", m0_gnt_o); end
      total++; if (m1_gnt_o !== 1'b0) begin bad++; $display("FAIL single_m1_gnt got=%b exp=0", m1_gnt_o); end
      total++; if (s_addr_o !== 32'h100) begin bad++; $display("FAIL single_addr got=%h exp=00000100", s_addr_o); end
      total++; if (m1_rvalid_o !== 1'b0) begin bad++; $display("FAIL single_m1_rvalid0 got=%b exp=0", m1_rvalid_o); end
      tick();
      m0_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; s_rdata_i = 32'hDEADBEEF;
      #1;
      total++; if (m0_rvalid_o !== 1'b1) begin bad++; $display("FAIL single_m0_rvalid got=%b exp=1", m0_rvalid_o); end
      total++; if (m0_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL single_m0_rdata got=%h exp=deadbeef", m0_rdata_o); end
      total++; if (m1_rvalid_o !== 1'b0) begin bad++; $display("FAIL single_m1_rvalid1 got=%b exp=0", m1_rvalid_o); end
      total++; if (m1_rdata_o !== 32'h0) begin bad++; $display("FAIL single_m1_rdata got=%h exp=0", m1_rdata_o); end
      tick();
      clear_inputs();
   endtask

   task automatic test_round_robin;
      int g, r;
      do_reset();
      m0_addr_i = 32'h200; m1_addr_i = 32'h300;
      for (int k = 0; k < 6; k++) begin
         m0_req_i = 1; m1_req_i = 1; s_gnt_i = 1;
         s_rvalid_i = (k > 0); s_rdata_i = 32'h1000 + k;
         g = k % 2; r = (k + 1) % 2;
         #1;
         total++; if (m0_gnt_o !== (g == 0)) begin bad++; $display("FAIL rr_m0_gnt k=%0d got=%b exp=%b", k, m0_gnt_o, g == 0); end
         total++; if (m1_gnt_o !== (g == 1)) begin bad++; $display("FAIL rr_m1_gnt k=%0d got=%b exp=%b", k, m1_gnt_o, g == 1); end
         total++; if (s_addr_o !== (g == 1 ? 32'h300 : 32'h200)) begin bad++; $display("FAIL rr_addr k=%0d got=%h", k, s_addr_o); end
         if (k > 0) begin
            total++; if (m0_rvalid_o !== (r == 0)) begin bad++; $display("FAIL rr_m0_rvalid k=%0d got=%b exp=%b", k, m0_rvalid_o, r == 0); end
            total++; if (m1_rvalid_o !== (r == 1)) begin bad++; $display("FAIL rr_m1_rvalid k=%0d got=%b exp=%b", k, m1_rvalid_o, r == 1); end
         end
         tick();
      end
      m0_req_i = 0; m1_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h1006;
      #1;
      total++; if (m1_rvalid_o !== 1'b1) begin bad++; $display("FAIL rr_last_m1_rvalid got=%b exp=1", m1_rvalid_o); end
      total++; if (m1_rdata_o !== 32'h1006) begin bad++; $display("FAIL rr_last_m1_rdata got=%h exp=00001006", m1_rdata_o); end
      tick();
      clear_inputs();
   endtask

   task automatic test_stall_lock;
      do_reset();
      m0_req_i = 1; m0_addr_i = 32'h400; m1_addr_i = 32'h500;
      for (int k = 0; k < 3; k++) begin
         m1_req_i = (k > 0); s_gnt_i = 0;
         #1;
         total++; if (s_req_o !== 1'b1) begin bad++; $display("FAIL stall_req k=%0d got=%b exp=1", k, s_req_o); end
         total++; if (s_addr_o !== 32'h400) begin bad++; $display("FAIL stall_addr k=%0d got=%h exp=00000400", k, s_addr_o); end
         total++; if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0) begin bad++; $display("FAIL stall_gnt k=%0d got=%b%b exp=00", k, m1_gnt_o, m0_gnt_o); end
         tick();
      end
      s_gnt_i = 1;
      #1;
      total++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin bad++; $display("FAIL stall_release got=%b%b exp=01", m1_gnt_o, m0_gnt_o); end
      tick();
      m0_req_i = 0;
      #1;
      total++; if (m1_gnt_o !== 1'b1) begin bad++; $display("FAIL stall_m1_next got=%b exp=1", m1_gnt_o); end
      total++; if (s_addr_o !== 32'h500) begin bad++; $display("FAIL stall_m1_addr got=%h exp=00000500", s_addr_o); end
      tick();
      m1_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; s_err_i = 1;
      #1;
      total++; if (m0_rvalid_o !== 1'b1 || m0_err_o !== 1'b1 || m1_err_o !== 1'b0) begin bad++; $display("FAIL stall_resp0 got rv=%b err=%b%b", m0_rvalid_o, m1_err_o, m0_err_o); end
      tick();
      s_err_i = 0;
      #1;
      total++; if (m1_rvalid_o !== 1'b1 || m0_rvalid_o !== 1'b0) begin bad++; $display("FAIL stall_resp1 got=%b%b exp=10", m1_rvalid_o, m0_rvalid_o); end
      tick();
      clear_inputs();
   endtask

   task automatic test_full;
      do_reset();
      m0_req_i = 1; m0_addr_i = 32'h600; s_gnt_i = 1;
      for (int k = 0; k < 2; k++) begin
         #1;
         total++; if (m0_gnt_o !== 1'b1) begin bad++; $display("FAIL full_fill k=%0d got=%b exp=1", k, m0_gnt_o); end
         tick();
      end
      #1;
      total++; if (s_req_o !== 1'b0) begin bad++; $display("FAIL full_req got=%b exp=0", s_req_o); end
      total++; if (m0_gnt_o !== 1'b0) begin bad++; $display("FAIL full_gnt got=%b exp=0", m0_gnt_o); end
      tick();
      s_rvalid_i = 1; s_rdata_i = 32'hA5;
      #1;
      total++; if (s_req_o !== 1'b0 || m0_gnt_o !== 1'b0) begin bad++; $display("FAIL full_pop_same got=%b%b exp=00", s_req_o, m0_gnt_o); end
      total++; if (m0_rvalid_o !== 1'b1) begin bad++; $display("FAIL full_pop_rvalid got=%b exp=1", m0_rvalid_o); end
      tick();
      s_rvalid_i = 0;
      #1;
      total++; if (m0_gnt_o !== 1'b1) begin bad++; $display("FAIL full_unblock got=%b exp=1", m0_gnt_o); end
      tick();
      m0_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1;
      for (int k = 0; k < 2; k++) begin
         #1;
         total++; if (m0_rvalid_o !== 1'b1) begin bad++; $display("FAIL full_drain k=%0d got=%b exp=1", k, m0_rvalid_o); end
         tick();
      end
      s_rvalid_i = 0;
      #1;
      total++; if (spurious_o !== 1'b0) begin bad++; $display("FAIL full_no_spurious got=%b exp=0", spurious_o); end
      clear_inputs();
   endtask

   task automatic test_spurious;
      do_reset();
      m0_req_i = 1; s_gnt_i = 1;
      tick();
      clear_inputs();
      rst_i = 1;
      tick();
      rst_i = 0;
      s_rvalid_i = 1; s_rdata_i = 32'h77;
      #1;
      total++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin bad++; $display("FAIL spur_rvalid got=%b%b exp=00", m1_rvalid_o, m0_rvalid_o); end
      tick();
      s_rvalid_i = 0;
      #1;
      total++; if (spurious_o !== 1'b1) begin bad++; $display("FAIL spur_set got=%b exp=1", spurious_o); end
      tick(); tick();
      total++; if (spurious_o !== 1'b1) begin bad++; $display("FAIL spur_sticky got=%b exp=1", spurious_o); end
      rst_i = 1;
      #1;
      total++; if (spurious_o !== 1'b0) begin bad++; $display("FAIL spur_clear got=%b exp=0", spurious_o); end
      tick();
      rst_i = 0;
   endtask

`ifdef ZEROHETI_ARB_DBG_PRIO_EN
   task automatic test_dbg_prio;
      do_reset();
      m0_req_i = 1; m1_req_i = 1; s_gnt_i = 1;
      for (int k = 0; k < 3; k++) begin
         s_rvalid_i = (k > 0);
         #1;
         total++; if (m1_gnt_o !== 1'b1 || m0_gnt_o !== 1'b0) begin bad++; $display("FAIL prio_m1 k=%0d got=%b%b exp=10", k, m1_gnt_o, m0_gnt_o); end
         tick();
      end
      m1_req_i = 0;
      #1;
      total++; if (m0_gnt_o !== 1'b1) begin bad++; $display("FAIL prio_m0 got=%b exp=1", m0_gnt_o); end
      total++; if (m1_rvalid_o !== 1'b1) begin bad++; $display("FAIL prio_resp got=%b exp=1", m1_rvalid_o); end
      tick();
      clear_inputs();
   endtask
`endif

   initial begin
      clear_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_stall_lock();
      test_full();
      test_spurious();
`ifdef ZEROHETI_ARB_DBG_PRIO_EN
      test_dbg_prio();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
